// File: rtl/dap_ahb_mem_bridge.sv
// rtl/dap_ahb_mem_bridge.sv - AHB-Lite slave bridging single transfers onto a register-file port
module dap_ahb_mem_bridge #(
  parameter int ADDRWIDTH = 12,
  parameter int READ_WAIT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 HSEL,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [31:0]          HWDATA,
  input  logic                 HREADY,
  output logic                 HREADYOUT,
  output logic                 HRESP,
  output logic [31:0]          HRDATA,
  output logic                 mem_write_en,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_byte_strobe,
  input  logic [31:0]          mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_WAIT_ST,
    READ,
    ERR1,
    ERR2
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(READ_WAIT > 0 ? READ_WAIT - 1 : 0);

  state_t                state;
  state_t                state_nxt;
  state_t                phase_state;
  logic [ADDRWIDTH-1:0]  addr_q;
  logic [3:0]            strobe_q;
  logic [3:0]            strobe_nxt;
  logic [3:0]            wait_cnt;
  logic                  illegal;
  logic                  ready;
  logic                  accept;
  logic                  unused_haddr;

  assign unused_haddr = ^HADDR[31:ADDRWIDTH];

  // Address phases are only taken on cycles where this slave is itself ready.
  assign ready  = (state != READ_WAIT_ST) && (state != ERR1);
  assign accept = ready && HSEL && HTRANS[1] && HREADY;

  always_comb begin
    strobe_nxt = 4'b0000;
    illegal    = 1'b0;
    case (HSIZE)
      3'd0: strobe_nxt = 4'b0001 << HADDR[1:0];
      3'd1: begin
        strobe_nxt = HADDR[1] ? 4'b1100 : 4'b0011;
        illegal    = HADDR[0];
      end
      3'd2: begin
        strobe_nxt = 4'b1111;
        illegal    = (HADDR[1:0] != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    phase_state = IDLE;
    if (illegal) begin
      phase_state = ERR1;
    end else if (HWRITE) begin
      phase_state = WRITE;
    end else if (READ_WAIT > 0) begin
      phase_state = READ_WAIT_ST;
    end else begin
      phase_state = READ;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, WRITE, READ, ERR2: state_nxt = accept ? phase_state : IDLE;
      READ_WAIT_ST: begin
        if (wait_cnt == WAIT_LAST) begin
          state_nxt = READ;
        end
      end
      ERR1:    state_nxt = ERR2;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      strobe_q <= 4'b0000;
      wait_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q   <= HADDR[ADDRWIDTH-1:0];
        strobe_q <= strobe_nxt;
      end
      if ((state == READ_WAIT_ST) && (state_nxt == READ_WAIT_ST)) begin
        wait_cnt <= wait_cnt + 4'd1;
      end else begin
        wait_cnt <= 4'd0;
      end
    end
  end

  // Outputs decode from registered state so reset clears them without waiting for a clock.
  assign HREADYOUT       = ready;
  assign HRESP           = (state == ERR1) || (state == ERR2);
  assign HRDATA          = (state == READ) ? mem_rdata : 32'd0;
  assign mem_write_en    = (state == WRITE);
  assign mem_wdata       = (state == WRITE) ? HWDATA : 32'd0;
  assign mem_addr        = addr_q;
  assign mem_byte_strobe = ((state == WRITE) || (state == READ_WAIT_ST) || (state == READ))
                           ? strobe_q : 4'b0000;

endmodule
